ahb_rr_master_ctrl: RTL

- Multi-requester AHB-Lite master front end: NUM_REQ local command ports share one AHB-Lite slave port (the ahb3liten slave) through a round-robin arbiter.
- Issues SINGLE NONSEQ transfers with overlapped address and data phases.
- Honours HREADY wait states and the two-cycle HRESP error response, and returns read data and status to the owning requester.
- Sits between the block's DMA/CPU-side requesters and the AHB slave interface.

---
 rtl/ahb_ctrl_pkg.sv | 37 +++
 rtl/ahb_rr_arbiter.sv | 69 ++++++
 rtl/ahb_rr_master_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ahb_ctrl_pkg.sv
// Shared AHB-Lite encodings and sizing helpers for the round-robin master front end.
package ahb_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } hburst_e;

    typedef enum logic [2:0] {
        BYTE  = 3'b000,
        HALF  = 3'b001,
        WORD  = 3'b010,
        DWORD = 3'b011
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Width of a requester/owner index; never below one bit.
    function automatic int unsigned owner_w(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/ahb_rr_arbiter.sv
// Round-robin requester selection: combinational winner search from a registered
// pointer that advances past each accepted winner.
module ahb_rr_arbiter
    import ahb_ctrl_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = owner_w(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic               i_enable,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDW-1:0]     o_winner,
    output logic               o_accept
);

    localparam logic [IDW:0]   NREQ = (IDW+1)'(NUM_REQ);
    localparam logic [IDW-1:0] LAST = IDW'(NUM_REQ - 1);

    logic [IDW-1:0] r_ptr;
    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_idx;
    logic [IDW-1:0] w_winner;
    logic           w_found;
    logic           w_hit;
    logic           w_accept;
    logic [NUM_REQ-1:0] w_grant;

    // Search upward from the pointer with wrap; the first valid requester wins.
    always_comb begin
        w_sum    = '0;
        w_idx    = '0;
        w_hit    = 1'b0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum    = {1'b0, r_ptr} + (IDW+1)'(i);
            w_idx    = (w_sum >= NREQ) ? IDW'(w_sum - NREQ) : IDW'(w_sum);
            w_hit    = i_req_valid[w_idx] && !w_found;
            w_winner = w_hit ? w_idx : w_winner;
            w_found  = w_found || w_hit;
        end
    end

    assign w_accept = w_found && i_enable;

    // One-hot grant, only when the bus can take a new address phase.
    always_comb begin
        w_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_grant[i] = w_accept && (w_winner == IDW'(i));
        end
    end

    // Pointer moves to the requester after the winner on every acceptance.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_winner == LAST) ? '0 : w_winner + 1'b1;
        end
    end

    assign o_grant  = w_grant;
    assign o_winner = w_winner;
    assign o_accept = w_accept;

endmodule

// File: rtl/ahb_rr_master_ctrl.sv
// AHB-Lite master front end: NUM_REQ command ports share one slave through a
// round-robin arbiter, issuing SINGLE NONSEQ transfers with pipelined data phases.
module ahb_rr_master_ctrl
    import ahb_ctrl_pkg::*;
#(
    parameter int         NUM_REQ   = 4,
    parameter int         ADDR_W    = 32,
    parameter int         DATA_W    = 32,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic                      hclk,
    input  logic                      hreset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*3-1:0]      req_size,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      hsel,
    output logic [ADDR_W-1:0]         haddr,
    output logic                      hwrite,
    output logic [2:0]                hsize,
    output logic [2:0]                hburst,
    output logic [3:0]                hprot,
    output logic [1:0]                htrans,
    output logic [DATA_W-1:0]         hwdata,
    input  logic                      hready,
    input  logic                      hresp,
    input  logic [DATA_W-1:0]         hrdata
);

    localparam int IDW = owner_w(NUM_REQ);

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] id);
        logic [NUM_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    logic [NUM_REQ-1:0] w_grant;
    logic [IDW-1:0]     w_winner;
    logic               w_accept;
    logic               w_err_any;
    logic               w_err1;
    logic               w_bus_free;
    logic               w_ap_busy;
    logic               w_cancel_join;
    logic               w_cancel_solo;
    logic [ADDR_W-1:0]  w_cmd_addr;
    logic               w_cmd_write;
    logic [2:0]         w_cmd_size;
    logic [DATA_W-1:0]  w_cmd_wdata;

    htrans_e            r_htrans;
    hburst_e            r_hburst;
    logic               r_hsel;
    logic [ADDR_W-1:0]  r_haddr;
    logic               r_hwrite;
    logic [2:0]         r_hsize;
    logic [3:0]         r_hprot;
    logic [IDW-1:0]     r_ap_owner;
    logic [DATA_W-1:0]  r_ap_wdata;
    logic               r_dp_valid;
    logic [IDW-1:0]     r_dp_owner;
    logic               r_dp_write;
    logic [DATA_W-1:0]  r_hwdata;
    logic               r_cancel_valid;
    logic [IDW-1:0]     r_cancel_owner;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic               r_rsp_err;

    // Both ERROR cycles block acceptance; cycle 1 also kills the pending address phase.
    assign w_err_any  = r_dp_valid && (hresp == HRESP_ERROR);
    assign w_err1     = w_err_any && !hready;
    assign w_bus_free = hready && !w_err_any;
    assign w_ap_busy  = (r_htrans == NONSEQ);

    ahb_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_clk       (hclk),
        .i_rst       (hreset),
        .i_req_valid (req_valid),
        .i_enable    (w_bus_free),
        .o_grant     (w_grant),
        .o_winner    (w_winner),
        .o_accept    (w_accept)
    );

    // AND-OR mux of the granted command; the grant is one-hot or zero.
    always_comb begin
        w_cmd_addr  = '0;
        w_cmd_write = 1'b0;
        w_cmd_size  = 3'b000;
        w_cmd_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cmd_addr  = w_cmd_addr  | (req_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{w_grant[i]}});
            w_cmd_write = w_cmd_write | (req_write[i] & w_grant[i]);
            w_cmd_size  = w_cmd_size  | (req_size[i*3 +: 3] & {3{w_grant[i]}});
            w_cmd_wdata = w_cmd_wdata | (req_wdata[i*DATA_W +: DATA_W] & {DATA_W{w_grant[i]}});
        end
    end

    // Address phase: load on acceptance, drop to IDLE on a free edge or ERROR cycle 1.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_htrans   <= IDLE;
            r_hsel     <= 1'b0;
            r_haddr    <= '0;
            r_hwrite   <= 1'b0;
            r_hsize    <= 3'b000;
            r_ap_owner <= '0;
            r_ap_wdata <= '0;
        end else if (w_accept) begin
            r_htrans   <= NONSEQ;
            r_hsel     <= 1'b1;
            r_haddr    <= w_cmd_addr;
            r_hwrite   <= w_cmd_write;
            r_hsize    <= w_cmd_size;
            r_ap_owner <= w_winner;
            r_ap_wdata <= w_cmd_wdata;
        end else if (hready || w_err1) begin
            r_htrans   <= IDLE;
            r_hsel     <= 1'b0;
        end
    end

    // Burst and protection are fixed for every transfer.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_hburst <= SINGLE;
            r_hprot  <= HPROT_VAL;
        end else begin
            r_hburst <= SINGLE;
            r_hprot  <= HPROT_VAL;
        end
    end

    // Data phase: a NONSEQ address phase advances on every HREADY edge.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_dp_valid <= 1'b0;
            r_dp_owner <= '0;
            r_dp_write <= 1'b0;
            r_hwdata   <= '0;
        end else if (hready) begin
            r_dp_valid <= w_ap_busy;
            if (w_ap_busy) begin
                r_dp_owner <= r_ap_owner;
                r_dp_write <= r_hwrite;
                r_hwdata   <= r_ap_wdata;
            end
        end
    end

    // A cancelled owner shares the errored response slot unless it is the same
    // requester, in which case it is reported on the following cycle.
    assign w_cancel_join = r_cancel_valid && hready && r_dp_valid && (r_cancel_owner != r_dp_owner);
    assign w_cancel_solo = r_cancel_valid && !r_dp_valid;

    // Track the address phase killed by ERROR cycle 1 until its owner is told.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_cancel_valid <= 1'b0;
            r_cancel_owner <= '0;
        end else if (w_err1 && w_ap_busy) begin
            r_cancel_valid <= 1'b1;
            r_cancel_owner <= r_ap_owner;
        end else if (w_cancel_join || w_cancel_solo) begin
            r_cancel_valid <= 1'b0;
        end
    end

    // Completion pulses and returned data/status.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (hready && r_dp_valid) begin
            r_rsp_valid <= onehot(r_dp_owner) | (w_cancel_join ? onehot(r_cancel_owner) : '0);
            r_rsp_rdata <= r_dp_write ? '0 : hrdata;
            r_rsp_err   <= hresp;
        end else if (w_cancel_solo) begin
            r_rsp_valid <= onehot(r_cancel_owner);
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
        end else begin
            r_rsp_valid <= '0;
        end
    end

    assign req_ready = w_grant;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign hsel      = r_hsel;
    assign haddr     = r_haddr;
    assign hwrite    = r_hwrite;
    assign hsize     = r_hsize;
    assign hburst    = r_hburst;
    assign hprot     = r_hprot;
    assign htrans    = r_htrans;
    assign hwdata    = r_hwdata;

endmodule
